// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

    localparam int TNEW_W = 2;
    localparam int TUSE_W = 2;

    typedef logic [TNEW_W-1:0] tnew_t;
    typedef logic [TUSE_W-1:0] tuse_t;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    function automatic tnew_t sat_dec(input tnew_t t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // $0 is hardwired, so a zero source never matches a producer.
    function automatic logic operand_hit(input logic used, input logic [4:0] src,
                                         input logic [4:0] dst);
        return used && (src != 5'd0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_pick(input logic hit_e, input tnew_t tnew_e,
                                            input logic hit_m, input tnew_t tnew_m,
                                            input logic hit_w, input tnew_t tnew_w);
        if (hit_e && tnew_e == '0) return FWD_E;
        if (hit_m && tnew_m == '0) return FWD_M;
        if (hit_w && tnew_w == '0) return FWD_W;
        return FWD_GRF;
    endfunction

endpackage

// File: rtl/hazard_stage_slot.sv
// One pipeline producer slot {dst, tnew} with bubble insertion and optional tnew decrement on load.
module hazard_stage_slot
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       bubble,
    input  logic       dec_en,
    input  logic [4:0] in_dst,
    input  tnew_t      in_tnew,
    output logic [4:0] dst,
    output tnew_t      tnew
);

    logic [4:0] dst_q, dst_d;
    tnew_t      tnew_q, tnew_d;

    always_comb begin
        dst_d  = in_dst;
        tnew_d = dec_en ? sat_dec(in_tnew) : in_tnew;
        if (bubble) begin
            dst_d  = 5'd0;
            tnew_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dst_q  <= 5'd0;
            tnew_q <= '0;
        end else begin
            dst_q  <= dst_d;
            tnew_q <= tnew_d;
        end
    end

    assign dst  = dst_q;
    assign tnew = tnew_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage stall/forward controller tracking E/M/W producers.
// Optional MDU busy stall is enabled by defining MDU_STALL_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic       id_rs_used,
    input  logic [1:0] id_rs_tuse,
    input  logic [4:0] id_rt,
    input  logic       id_rt_used,
    input  logic [1:0] id_rt_tuse,
    input  logic [4:0] id_dst,
    input  logic [1:0] id_tnew,
    input  logic       id_md_start,
    input  logic       id_md_div,
    input  logic       id_md_use,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       md_busy
);

    logic [4:0] e_dst, m_dst, w_dst;
    tnew_t      e_tnew, m_tnew, w_tnew;

    hazard_stage_slot u_slot_e (
        .clk(clk), .reset(reset), .bubble(stall), .dec_en(1'b0),
        .in_dst(id_dst), .in_tnew(id_tnew), .dst(e_dst), .tnew(e_tnew)
    );
    hazard_stage_slot u_slot_m (
        .clk(clk), .reset(reset), .bubble(1'b0), .dec_en(1'b1),
        .in_dst(e_dst), .in_tnew(e_tnew), .dst(m_dst), .tnew(m_tnew)
    );
    hazard_stage_slot u_slot_w (
        .clk(clk), .reset(reset), .bubble(1'b0), .dec_en(1'b1),
        .in_dst(m_dst), .in_tnew(m_tnew), .dst(w_dst), .tnew(w_tnew)
    );

    logic rs_hit_e, rs_hit_m, rs_hit_w;
    logic rt_hit_e, rt_hit_m, rt_hit_w;
    logic stall_rs, stall_rt, stall_md;

    always_comb begin
        rs_hit_e = operand_hit(id_rs_used, id_rs, e_dst);
        rs_hit_m = operand_hit(id_rs_used, id_rs, m_dst);
        rs_hit_w = operand_hit(id_rs_used, id_rs, w_dst);
        rt_hit_e = operand_hit(id_rt_used, id_rt, e_dst);
        rt_hit_m = operand_hit(id_rt_used, id_rt, m_dst);
        rt_hit_w = operand_hit(id_rt_used, id_rt, w_dst);

        // W always holds tnew 0, so it can only forward, never stall.
        stall_rs = (rs_hit_e && e_tnew > id_rs_tuse) || (rs_hit_m && m_tnew > id_rs_tuse);
        stall_rt = (rt_hit_e && e_tnew > id_rt_tuse) || (rt_hit_m && m_tnew > id_rt_tuse);

        fwd_rs_sel = fwd_pick(rs_hit_e, e_tnew, rs_hit_m, m_tnew, rs_hit_w, w_tnew);
        fwd_rt_sel = fwd_pick(rt_hit_e, e_tnew, rt_hit_m, m_tnew, rt_hit_w, w_tnew);
    end

`ifdef MDU_STALL_EN
    localparam int MD_W = 8;
    logic [MD_W-1:0] md_cnt_q, md_cnt_d;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (id_md_start && !stall)
            md_cnt_d = id_md_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) md_cnt_q <= '0;
        else       md_cnt_q <= md_cnt_d;
    end

    assign md_busy = (md_cnt_q != '0);
`else
    logic unused_md;
    assign unused_md = ^{id_md_start, id_md_div, MULT_CYCLES[0], DIV_CYCLES[0]};
    assign md_busy   = 1'b0;
`endif

    assign stall_md = id_md_use && md_busy;
    assign stall    = stall_rs || stall_rt || stall_md;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed + randomized bench for hazard_scoreboard against a cycle-stamped producer-history model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
    logic       id_rs_used = 1'b0, id_rt_used = 1'b0;
    logic [1:0] id_rs_tuse = '0, id_rt_tuse = '0, id_tnew = '0;
    logic       id_md_start = 1'b0, id_md_div = 1'b0, id_md_use = 1'b0;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    hazard_scoreboard #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rs_tuse(id_rs_tuse),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rt_tuse(id_rt_tuse),
        .id_dst(id_dst), .id_tnew(id_tnew),
        .id_md_start(id_md_start), .id_md_div(id_md_div), .id_md_use(id_md_use),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Model: every instruction entering E is stamped with the cycle its result becomes ready.
    int hdst   [0:4095];
    int hready [0:4095];
    int cyc;
    int busy_until;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int remaining(input int k);
        int r;
        r = hready[cyc-k] - cyc;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic logic hits(input int k, input logic [4:0] src, input logic used);
        return used && src != 0 && hdst[cyc-k] == int'(src);
    endfunction

    function automatic logic op_stall(input logic [4:0] src, input logic used, input logic [1:0] tuse);
        for (int k = 0; k < 2; k++)
            if (hits(k, src, used) && remaining(k) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] op_fwd(input logic [4:0] src, input logic used);
        for (int k = 0; k < 3; k++)
            if (hits(k, src, used) && remaining(k) == 0) return 2'(k + 1);
        return 2'd0;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            hdst[cyc-k]   = 0;
            hready[cyc-k] = 0;
        end
        busy_until = 0;
    endtask

    task automatic step(input logic rst, input logic [4:0] dst, input logic [1:0] tnew,
                        input logic [4:0] rs, input logic rsu, input logic [1:0] rsuse,
                        input logic [4:0] rt, input logic rtu, input logic [1:0] rttuse,
                        input logic ms, input logic mdv, input logic mu, output logic st);
        logic busy, e_stall;
        @(negedge clk);
        reset = rst; id_dst = dst; id_tnew = tnew;
        id_rs = rs; id_rs_used = rsu; id_rs_tuse = rsuse;
        id_rt = rt; id_rt_used = rtu; id_rt_tuse = rttuse;
        id_md_start = ms; id_md_div = mdv; id_md_use = mu;
        #1;
`ifdef MDU_STALL_EN
        busy = cyc < busy_until;
`else
        busy = 1'b0;
`endif
        e_stall = op_stall(rs, rsu, rsuse) | op_stall(rt, rtu, rttuse) | (mu & busy);
        check("stall", {7'd0, stall}, {7'd0, e_stall});
        check("fwd_rs", {6'd0, fwd_rs_sel}, {6'd0, op_fwd(rs, rsu)});
        check("fwd_rt", {6'd0, fwd_rt_sel}, {6'd0, op_fwd(rt, rtu)});
        check("md_busy", {7'd0, md_busy}, {7'd0, busy});
        st = e_stall;
        @(posedge clk);
        cyc++;
        if (rst) begin
            clear_model();
        end else begin
            hdst[cyc]   = e_stall ? 0 : int'(dst);
            hready[cyc] = e_stall ? 0 : cyc + int'(tnew);
            if (ms && !e_stall) busy_until = cyc + (mdv ? 10 : 5);
        end
    endtask

    logic st;
    int   n_st;

    initial begin
        cyc = 8;
        clear_model();
        repeat (2) @(posedge clk);

        // Reset state with idle ID inputs
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);

        // lw $1 -> addu $2,$1,$3: one stall cycle
        step(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
        n_st = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 2, 1, 1, 1, 1, 3, 1, 1, 0, 0, 0, st);
            if (!st) break;
            n_st++;
        end
        check("t1_stall_cycles", 8'(n_st), 8'd1);

        // lw $1 -> beq $1,$0: two stall cycles
        step(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
        n_st = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, st);
            if (!st) break;
            n_st++;
        end
        check("t2_stall_cycles", 8'(n_st), 8'd2);

        // addu $4 -> sw rt=$4 (tuse 2): no stall, then forward on the following cycles
        step(0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
        step(0, 0, 0, 6, 1, 1, 4, 1, 2, 0, 0, 0, st);
        check("t3_no_stall", {7'd0, st}, 8'd0);
        step(0, 0, 0, 6, 1, 1, 4, 1, 2, 0, 0, 0, st);

        // Writes to $0 never create a hazard
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
        @(negedge clk);
        id_dst = 5'd7; id_tnew = 2'd1; id_rs = 5'd0; id_rs_used = 1'b1; id_rs_tuse = 2'd1;
        id_rt = 5'd0; id_rt_used = 1'b1; id_rt_tuse = 2'd0;
        #1;
        check("t4_fwd_rs_zero", {6'd0, fwd_rs_sel}, 8'd0);
        check("t4_stall_zero", {7'd0, stall}, 8'd0);
        step(0, 7, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, st);

        // div then mflo, then mult then mflo
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, st);
        n_st = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, st);
            if (!st) break;
            n_st++;
        end
`ifdef MDU_STALL_EN
        check("t5_div_stall", 8'(n_st), 8'd10);
`else
        check("t5_div_stall", 8'(n_st), 8'd0);
`endif
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, st);
        n_st = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, st);
            if (!st) break;
            n_st++;
        end
`ifdef MDU_STALL_EN
        check("t5_mult_stall", 8'(n_st), 8'd5);
`else
        check("t5_mult_stall", 8'(n_st), 8'd0);
`endif

        // Reset during the load-use stall of a branch
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, st);
        step(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
        step(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1, st);
        check("t6_stalled_before_reset", {7'd0, st}, 8'd1);
        step(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1, st);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_stall_after_reset", {7'd0, stall}, 8'd0);
        check("t6_fwd_rs_after_reset", {6'd0, fwd_rs_sel}, 8'd0);
        check("t6_fwd_rt_after_reset", {6'd0, fwd_rt_sel}, 8'd0);
        check("t6_md_busy_after_reset", {7'd0, md_busy}, 8'd0);

        // Randomized traffic over a small register set to make hits frequent
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                 ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), st);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
